modadd_serial_ctrl: RTL and testbench

- Sequencing controller for the modular adder/subtractor datapath.
- Computes (a + b) mod M or (a - b) mod M bit-serially, LSB first, over N-bit operands.
- Every serial bit slice is built from two first-stage HAL cells: a = AND/generate, b = XOR/propagate, plus a carry/borrow flop.
- The controller latches operands and runs a main pass then a correction pass, with a start/busy/done handshake towards the host.

---
 rtl/modadd_serial_ctrl.sv | 132 +++++++++++++
 tb/tb_modadd_serial_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/modadd_serial_ctrl.sv
// rtl/modadd_serial_ctrl.sv - bit-serial (a +/- b) mod M controller with main and correction passes
module modadd_serial_ctrl #(
  parameter int N = 4,
  parameter int M = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N-1:0] result
);

  localparam int             CW        = $clog2(N + 1);
  localparam logic [N:0]     MOD       = (N + 1)'(M);
  localparam logic [CW-1:0]  LAST_ADD  = CW'(N - 1);
  localparam logic [CW-1:0]  LAST_CORR = CW'(N);

  typedef enum logic [1:0] {IDLE, ADD, CORR, DONE} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  ra, rb, s, t;
  logic          rsub, carry, cbw, err_wait;
  logic [CW-1:0] cnt;
  logic [N:0]    a_ext, b_ext, s_ext;
  logic          x, y, g, p, sum, cout, bad;

  assign a_ext = {1'b0, ra};
  assign b_ext = {1'b0, rb};
  assign s_ext = {cbw, s};
  assign bad   = ({1'b0, a} >= MOD) || ({1'b0, b} >= MOD);

  // One serial slice: HAL generate/propagate cells plus the carry flop.
  always_comb begin
    x = 1'b0;
    y = 1'b0;
    case (state)
      ADD: begin
        x = a_ext[cnt];
        y = b_ext[cnt] ^ rsub;
      end
      CORR: begin
        x = s_ext[cnt];
        y = rsub ? MOD[cnt] : ~MOD[cnt];
      end
      default: ;
    endcase
    g    = x & y;
    p    = x ^ y;
    sum  = p ^ carry;
    cout = g | (p & carry);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = bad ? DONE : ADD;
      ADD:  if (cnt == LAST_ADD) state_nx = CORR;
      CORR: if (cnt == LAST_CORR) state_nx = DONE;
      DONE: if (!err_wait) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == ADD) || (state == CORR);
  assign done = (state == DONE) && !err_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ra       <= '0;
      rb       <= '0;
      s        <= '0;
      t        <= '0;
      rsub     <= 1'b0;
      carry    <= 1'b0;
      cbw      <= 1'b0;
      err_wait <= 1'b0;
      cnt      <= '0;
      err      <= 1'b0;
      result   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            ra     <= a;
            rb     <= b;
            rsub   <= sub;
            carry  <= sub;
            cbw    <= 1'b0;
            s      <= '0;
            t      <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= bad;
            // Range errors spend one extra cycle in DONE before done asserts.
            err_wait <= bad;
          end
        end
        ADD: begin
          s     <= {sum, s[N-1:1]};
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_ADD) begin
            cnt   <= '0;
            cbw   <= rsub ? ~cout : cout;
            // Correction subtracts M for add (carry-in 1), adds M for sub.
            carry <= ~rsub;
          end
        end
        CORR: begin
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (cnt != LAST_CORR) t <= {sum, t[N-1:1]};
          if (cnt == LAST_CORR) begin
            cnt <= '0;
            if (rsub) result <= cbw ? t : s;
            else      result <= cout ? t : s;
          end
        end
        DONE: err_wait <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modadd_serial_ctrl.sv
// tb/tb_modadd_serial_ctrl.sv - scoreboard bench for modadd_serial_ctrl (N=4, M=13)
module tb_modadd_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, sub;
  logic [3:0] a, b, result;
  logic       busy, done, err;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;

  always #5 clk = ~clk;

  modadd_serial_ctrl #(.N(4), .M(13)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected {err,result}.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("err", int'(err), int'(mon_e[4]));
        chk("result", int'(result), int'(mon_e[3:0]));
      end
    end
  end

  task automatic issue(input logic s_, input logic [3:0] a_, input logic [3:0] b_);
    @(negedge clk);
    start = 1'b1; sub = s_; a = a_; b = b_;
    @(posedge clk);
    #1;
    start = 1'b0; sub = ~s_; a = ~a_; b = ~b_;
  endtask

  // Edges counted from the edge that accepted start (or from where the wait began).
  task automatic wait_done(output int edges, output int bcnt);
    bit seen;
    seen  = 1'b0;
    edges = -1;
    bcnt  = 0;
    while (!seen && edges < 40) begin
      @(negedge clk);
      edges++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) bcnt++;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic op(input logic s_, input logic [3:0] a_, input logic [3:0] b_,
                    input logic e_, input logic [3:0] r_, input int lat, input int bexp);
    int edges, bcnt;
    exp_q.push_back({e_, r_});
    issue(s_, a_, b_);
    wait_done(edges, bcnt);
    chk("latency", edges, lat);
    chk("busy_cycles", bcnt, bexp);
  endtask

  initial begin
    int edges, bcnt;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = 4'd0; b = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_result", int'(result), 0);

    op(1'b0, 4'd7,  4'd9,  1'b0, 4'd3,  9, 9);
    op(1'b1, 4'd3,  4'd9,  1'b0, 4'd7,  9, 9);
    op(1'b1, 4'd5,  4'd5,  1'b0, 4'd0,  9, 9);
    op(1'b0, 4'd12, 4'd12, 1'b0, 4'd11, 9, 9);
    op(1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  9, 9);

    op(1'b0, 4'd13, 4'd2,  1'b1, 4'd0,  1, 0);
    op(1'b1, 4'd2,  4'd15, 1'b1, 4'd0,  1, 0);
    op(1'b0, 4'd4,  4'd5,  1'b0, 4'd9,  9, 9);

    // Start pulsed at edge k+3 of a running add must be ignored.
    exp_q.push_back({1'b0, 4'd3});
    issue(1'b0, 4'd7, 4'd9);
    repeat (3) @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 4'd1; b = 4'd2;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(edges, bcnt);
    chk("ignored_start_latency", edges, 6);
    repeat (12) @(negedge clk);
    op(1'b1, 4'd1, 4'd2, 1'b0, 4'd12, 9, 9);

    // Reset at edge k+5 aborts without a done pulse.
    issue(1'b0, 4'd7, 4'd9);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    op(1'b0, 4'd4, 4'd4, 1'b0, 4'd8, 9, 9);

    // Start held high: back-to-back operations, second accepted right after DONE.
    exp_q.push_back({1'b0, 4'd3});
    exp_q.push_back({1'b0, 4'd3});
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 4'd7; b = 4'd9;
    wait_done(edges, bcnt);
    chk("held_first_latency", edges, 9);
    wait_done(edges, bcnt);
    chk("held_second_gap", edges, 10);
    start = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < 13; j++) begin
        op(1'b0, 4'(i), 4'(j), 1'b0, 4'((i + j) % 13), 9, 9);
        op(1'b1, 4'(i), 4'(j), 1'b0, 4'((i - j + 13) % 13), 9, 9);
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
